noc_rx_monitor: RTL and testbench

- Receive-side sink for one PE port of the HNoC; consumes the packet stream the network delivers to that PE.
- Checks each packet's destination field and computes per-packet latency from an injection timestamp carried in the payload.
- Accumulates count, min, max and sum of latency, and raises done when the expected packet quota arrives.
- Also drives the free-running timestamp that the local PE traffic generator stamps into injected packets, so both share one time base.

---
 rtl/noc_rx_monitor.sv | 123 ++++++++++++
 tb/tb_noc_rx_monitor.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_rx_monitor.sv
// Receive-side sink for one HNoC PE port: destination check, latency statistics and the shared timestamp.
// Optional random back-pressure on o_data_ready is enabled by defining NOC_RX_STALL_EN.
module noc_rx_monitor #(
   parameter int ADDRESS      = 0,
   parameter int AddressWidth = 4,
   parameter int DataWidth    = 32,
   parameter int TotalWidth   = DataWidth + AddressWidth,
   parameter int PktLimit     = 100,
   parameter int SumWidth     = 48
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [TotalWidth-1:0] i_data,
   input  logic                  i_data_valid,
   output logic                  o_data_ready,
   output logic [DataWidth-1:0]  o_timestamp,
   output logic                  o_lat_valid,
   output logic [DataWidth-1:0]  o_lat_value,
   output logic [31:0]           o_rx_count,
   output logic [DataWidth-1:0]  o_lat_min,
   output logic [DataWidth-1:0]  o_lat_max,
   output logic [SumWidth-1:0]   o_lat_sum,
   output logic                  o_addr_err,
   output logic                  o_overflow,
   output logic                  o_done
);

   typedef enum logic {
      S_RUN,
      S_DONE
   } state_t;

   state_t state;

   logic [AddressWidth-1:0] pkt_dest;
   logic [DataWidth-1:0]    pkt_stamp;
   logic                    accept;
   logic                    dest_ok;
   logic [DataWidth-1:0]    lat;
   logic [SumWidth:0]       sum_ext;
   logic [SumWidth-1:0]     sum_sat;
   logic [31:0]             count_next;
   logic                    hits_limit;
   logic                    ready_next;

   assign pkt_dest   = i_data[TotalWidth-1 -: AddressWidth];
   assign pkt_stamp  = i_data[DataWidth-1:0];
   assign accept     = i_data_valid && o_data_ready;
   assign dest_ok    = (pkt_dest == AddressWidth'(ADDRESS));

   // Modular subtraction makes a timestamp wrap between injection and arrival harmless.
   assign lat        = o_timestamp - pkt_stamp;
   assign sum_ext    = {1'b0, o_lat_sum} + (SumWidth + 1)'(lat);
   assign sum_sat    = sum_ext[SumWidth] ? '1 : sum_ext[SumWidth-1:0];
   assign count_next = o_rx_count + 32'd1;
   assign hits_limit = (count_next == 32'(PktLimit));

`ifdef NOC_RX_STALL_EN
   logic [15:0] lfsr;
   logic        lfsr_fb;

   // Fibonacci taps 16,14,13,11 on a left-shifting register.
   assign lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
   assign ready_next = (lfsr[1:0] != 2'b00);

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr <= 16'hACE1;
      end else begin
         lfsr <= {lfsr[14:0], lfsr_fb};
      end
   end
`else
   assign ready_next = 1'b1;
`endif

   // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_RUN;
         o_data_ready <= 1'b0;
         o_timestamp  <= '0;
         o_lat_valid  <= 1'b0;
         o_lat_value  <= '0;
         o_rx_count   <= '0;
         o_lat_min    <= '1;
         o_lat_max    <= '0;
         o_lat_sum    <= '0;
         o_addr_err   <= 1'b0;
         o_overflow   <= 1'b0;
         o_done       <= 1'b0;
      end else begin
         o_timestamp  <= o_timestamp + DataWidth'(1);
         o_data_ready <= ready_next;
         o_lat_valid  <= 1'b0;

         if (accept) begin
            if (!dest_ok) begin
               o_addr_err <= 1'b1;
            end else begin
               unique case (state)
                  S_RUN: begin
                     o_lat_valid <= 1'b1;
                     o_lat_value <= lat;
                     o_rx_count  <= count_next;
                     o_lat_sum   <= sum_sat;
                     if (lat < o_lat_min) o_lat_min <= lat;
                     if (lat > o_lat_max) o_lat_max <= lat;
                     if (hits_limit) begin
                        state  <= S_DONE;
                        o_done <= 1'b1;
                     end
                  end
                  S_DONE: begin
                     o_overflow <= 1'b1;
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_noc_rx_monitor.sv
// Randomised plus directed bench for noc_rx_monitor against a queue-based reference model.
// Build with NOC_RX_STALL_EN defined to exercise the back-pressure variant.
module tb_noc_rx_monitor;

   localparam int AW    = 4;
   localparam int DW    = 32;
   localparam int TW    = DW + AW;
   localparam int ADDR  = 5;
   localparam int LIMIT = 4;
   localparam int SW    = 48;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [TW-1:0] i_data = '0;
   logic          i_data_valid = 1'b0;
   logic          o_data_ready;
   logic [DW-1:0] o_timestamp;
   logic          o_lat_valid;
   logic [DW-1:0] o_lat_value;
   logic [31:0]   o_rx_count;
   logic [DW-1:0] o_lat_min;
   logic [DW-1:0] o_lat_max;
   logic [SW-1:0] o_lat_sum;
   logic          o_addr_err;
   logic          o_overflow;
   logic          o_done;

   always #5 clk = ~clk;

   noc_rx_monitor #(
      .ADDRESS     (ADDR),
      .AddressWidth(AW),
      .DataWidth   (DW),
      .TotalWidth  (TW),
      .PktLimit    (LIMIT),
      .SumWidth    (SW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_data      (i_data),
      .i_data_valid(i_data_valid),
      .o_data_ready(o_data_ready),
      .o_timestamp (o_timestamp),
      .o_lat_valid (o_lat_valid),
      .o_lat_value (o_lat_value),
      .o_rx_count  (o_rx_count),
      .o_lat_min   (o_lat_min),
      .o_lat_max   (o_lat_max),
      .o_lat_sum   (o_lat_sum),
      .o_addr_err  (o_addr_err),
      .o_overflow  (o_overflow),
      .o_done      (o_done)
   );

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   // Reference model: time since release, list of accepted latencies, sticky flags.
   bit [31:0]   m_ts = '0;
   bit          m_ready = 1'b0;
   bit [31:0]   m_lats[$];
   bit          m_addr_err = 1'b0;
   bit          m_overflow = 1'b0;
   bit          m_lat_valid = 1'b0;
   bit [31:0]   m_lat_value = '0;
   bit          last_rdy = 1'b0;
   int unsigned ready_low = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   function automatic logic [TW-1:0] pkt(input logic [AW-1:0] dest, input logic [DW-1:0] stamp);
      return {dest, stamp};
   endfunction

   task automatic model_edge(input bit r, input bit v, input logic [TW-1:0] d, input bit rdy);
      bit [31:0] lat;
      if (r) begin
         m_ts = '0; m_ready = 1'b0; m_lats.delete();
         m_addr_err = 1'b0; m_overflow = 1'b0; m_lat_valid = 1'b0; m_lat_value = '0;
         return;
      end
      m_lat_valid = 1'b0;
      if (v && rdy) begin
         lat = m_ts - d[DW-1:0];
         if (d[TW-1 -: AW] != AW'(ADDR)) m_addr_err = 1'b1;
         else if (m_lats.size() == LIMIT) m_overflow = 1'b1;
         else begin
            m_lats.push_back(lat);
            m_lat_valid = 1'b1;
            m_lat_value = lat;
         end
      end
      m_ts = m_ts + 32'd1;
      m_ready = 1'b1;
   endtask

   task automatic compare_all();
      bit [31:0]       mn = 32'hFFFF_FFFF;
      bit [31:0]       mx = '0;
      longint unsigned sm = 0;
      longint unsigned sat = (64'd1 << SW) - 1;
      foreach (m_lats[i]) begin
         if (m_lats[i] < mn) mn = m_lats[i];
         if (m_lats[i] > mx) mx = m_lats[i];
         sm = sm + m_lats[i];
         if (sm > sat) sm = sat;
      end
`ifndef NOC_RX_STALL_EN
      check("ready", o_data_ready, m_ready);
`endif
      check("timestamp", o_timestamp, m_ts);
      check("lat_valid", o_lat_valid, m_lat_valid);
      check("lat_value", o_lat_value, m_lat_value);
      check("rx_count", o_rx_count, m_lats.size());
      check("lat_min", o_lat_min, mn);
      check("lat_max", o_lat_max, mx);
      check("lat_sum", o_lat_sum, sm);
      check("addr_err", o_addr_err, m_addr_err);
      check("overflow", o_overflow, m_overflow);
      check("done", o_done, m_lats.size() == LIMIT);
   endtask

   // Drive one cycle; inputs change #1 after an edge, outputs are checked #1 after the next edge.
   task automatic cycle(input bit v, input logic [TW-1:0] d, input bit r);
      rst = r; i_data_valid = v; i_data = d;
`ifdef NOC_RX_STALL_EN
      last_rdy = (o_data_ready === 1'b1);
      if (!r && !last_rdy) ready_low++;
`else
      last_rdy = m_ready;
`endif
      @(posedge clk);
      model_edge(r, v, d, last_rdy);
      #1;
      compare_all();
      i_data_valid = 1'b0;
   endtask

   // Offer a packet with the given latency until it is accepted (bounded).
   task automatic send_lat(input logic [AW-1:0] dest, input int unsigned lat);
      bit done = 1'b0;
      for (int k = 0; k < 64 && !done; k++) begin
         cycle(1'b1, pkt(dest, m_ts - 32'(lat)), 1'b0);
         done = last_rdy;
      end
      check("send_accepted", done, 1'b1);
   endtask

   task automatic do_reset(input int n);
      for (int k = 0; k < n; k++) cycle(1'b0, '0, 1'b1);
   endtask

   initial begin
      // Reset state and idle time base
      do_reset(3);
      check("reset_ts", o_timestamp, 0);
      check("reset_min", o_lat_min, 32'hFFFF_FFFF);
      repeat (20) cycle(1'b0, '0, 1'b0);
      check("idle_ts20", o_timestamp, 20);
      check("idle_count", o_rx_count, 0);
      check("idle_min", o_lat_min, 32'hFFFF_FFFF);
      check("idle_done", o_done, 0);

      // Two valid packets, latencies 7 then 3
      send_lat(4'(ADDR), 7);
      check("lat7_valid", o_lat_valid, 1);
      check("lat7_value", o_lat_value, 7);
      send_lat(4'(ADDR), 3);
      check("lat3_valid", o_lat_valid, 1);
      check("lat3_value", o_lat_value, 3);
      cycle(1'b0, '0, 1'b0);
      check("pulse_ends", o_lat_valid, 0);
      check("two_min", o_lat_min, 3);
      check("two_max", o_lat_max, 7);
      check("two_sum", o_lat_sum, 10);
      check("two_count", o_rx_count, 2);

      // Misrouted packet
      send_lat(4'd9, 2);
      check("misroute_err", o_addr_err, 1);
      check("misroute_nopulse", o_lat_valid, 0);
      check("misroute_count", o_rx_count, 2);
      cycle(1'b0, '0, 1'b0);
      check("misroute_sticky", o_addr_err, 1);

      // Quota and overflow
      send_lat(4'(ADDR), 1);
      check("q3_done", o_done, 0);
      send_lat(4'(ADDR), 0);
      check("q4_done", o_done, 1);
      check("q4_count", o_rx_count, 4);
      check("q4_min0", o_lat_min, 0);
      send_lat(4'(ADDR), 2);
      check("over_flag", o_overflow, 1);
      check("over_count", o_rx_count, 4);
      check("over_nopulse", o_lat_valid, 0);

      // Stamp taken just before a wrap of the time base
      do_reset(1);
      cycle(1'b0, '0, 1'b0);
      cycle(1'b0, '0, 1'b0);
`ifndef NOC_RX_STALL_EN
      cycle(1'b1, pkt(4'(ADDR), 32'hFFFF_FFFE), 1'b0);
      check("wrap_lat", o_lat_value, 4);
`endif

      // Reset mid-operation with a packet in flight
      do_reset(1);
      cycle(1'b0, '0, 1'b0);
      send_lat(4'(ADDR), 3);
      send_lat(4'd9, 1);
      send_lat(4'(ADDR), 4);
      cycle(1'b1, pkt(4'(ADDR), 32'd0), 1'b1);
      cycle(1'b0, '0, 1'b0);
      send_lat(4'(ADDR), 9);
      check("rst_count", o_rx_count, 1);
      check("rst_min", o_lat_min, 9);
      check("rst_max", o_lat_max, 9);
      check("rst_sum", o_lat_sum, 9);
      check("rst_done", o_done, 0);
      check("rst_addr_err", o_addr_err, 0);
      check("rst_overflow", o_overflow, 0);

      // Random traffic against the model
      for (int round = 0; round < 8; round++) begin
         do_reset(1);
         for (int c = 0; c < 80; c++) begin
            logic [AW-1:0] dest;
            logic [DW-1:0] stamp;
            bit            v;
            v     = ($urandom_range(0, 9) < 7);
            dest  = ($urandom_range(0, 99) < 85) ? AW'(ADDR) : AW'($urandom_range(0, 15));
            stamp = ($urandom_range(0, 15) == 0) ? DW'($urandom) : m_ts - DW'($urandom_range(0, 40));
            cycle(v, pkt(dest, stamp), ($urandom_range(0, 63) == 0));
         end
      end

`ifdef NOC_RX_STALL_EN
      begin
         int unsigned n_acc = 0;
         do_reset(1);
         ready_low = 0;
         for (int c = 0; c < 2000 && n_acc < 200; c++) begin
            cycle(1'b1, pkt(4'(ADDR), m_ts - DW'($urandom_range(0, 20))), 1'b0);
            if (last_rdy) n_acc++;
         end
         check("stall_accepts", n_acc, 200);
         check("stall_ready_low_seen", ready_low != 0, 1);
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
